req_arbiter16: RTL and testbench
================================

// Module: req_arbiter16
// PURPOSE
//  Arbitrates 16 requesters for one shared resource. Selectable fixed or round-robin priority.
//  Issues a registered one-hot grant plus its encoded index, and holds the grant until the owner releases it.
//  Index numbering follows the codebase priority-encoder convention: index 0 = req[N-1] (MSB), index N-1 = req[0].
//  Sits in front of any shared datapath; gnt_idx drives that datapath's select mux directly.
// PARAMETERS
//  N         16   number of requesters
//  IDX_W     4    index width, $clog2(N)
//  MAX_HOLD  64   max consecutive grant cycles before forced release; 0 = no limit
//  HOLD_W    7    hold-counter width, >= $clog2(MAX_HOLD+1)
// PORTS
//  clk        in   1      clock; all logic on rising edge
//  rst        in   1      synchronous, active-high reset
//  rr_en      in   1      1 = round-robin, 0 = fixed priority (index 0 highest); sampled only in IDLE
//  req        in   N      request vector; requester k drives req[N-1-k]
//  gnt        out  N      one-hot grant, same bit mapping as req; registered
//  gnt_idx    out  IDX_W  index of the current grant; valid only while gnt_valid=1
//  gnt_valid  out  1      1 while any grant is held; equals |gnt
//  timeout    out  1      one-cycle pulse when a grant is force-released by MAX_HOLD
// BEHAVIOUR
//  Reset (rst=1 at an edge, in any state, including mid-grant):
//   - Next cycle: gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, ptr=0, hold_cnt=0, state=IDLE.
//  FSM states: IDLE, GRANT.
//  IDLE:
//   - If req==0, stay in IDLE with all outputs 0.
//   - Otherwise select the first requesting index k, scanning ascending and wrapping mod N:
//     from ptr when rr_en=1, from 0 when rr_en=0.
//   - Next edge: state=GRANT, gnt=one-hot(k), gnt_idx=k, gnt_valid=1, hold_cnt=1.
//   - Latency: req sampled at edge t -> gnt visible after edge t+1.
//  GRANT (owner g = gnt_idx):
//   - Owner releases by dropping its req bit. If req bit of g=0 at an edge: state=IDLE, gnt=0, gnt_valid=0.
//   - Forced release: if MAX_HOLD!=0, hold_cnt==MAX_HOLD and req of g is still 1 at an edge:
//     state=IDLE, gnt=0, timeout=1 for that one cycle.
//   - Otherwise stay in GRANT; hold_cnt increments and saturates at MAX_HOLD.
//     Other req bits are ignored; no preemption.
//   - Any release (normal or forced) with rr_en=1: ptr=(g+1) mod N. With rr_en=0: ptr unchanged.
//  Dead cycle: exactly one IDLE cycle (gnt=0) always separates consecutive grants.
//   - Max grant rate is one grant per (hold+1) cycles.
//  Simultaneous owner-drop and hold limit on the same edge: treated as a normal release, timeout=0.
//  A force-released requester still asserting req may win again.
//   - Under round-robin, all other active requesters are served first.
//  rr_en changes during GRANT take effect at the next IDLE arbitration only.
//  gnt is always one-hot or zero. gnt_idx holds its last value when gnt_valid=0 (don't-care).
// TESTING
//  1 Reset: drive req=16'hFFFF, rst=1 for 2 cycles
//    -> gnt=0, gnt_valid=0, timeout=0; first grant after rst drops is idx 0 (gnt=16'h8000).
//  2 Fixed priority: rr_en=0, req=16'h0081
//    -> gnt=16'h0080, idx 8; drop bit 7 -> 1 idle cycle -> gnt=16'h0001, idx 15.
//  3 Round-robin: rr_en=1, all 16 requesters request; each drops req 3 cycles after grant for 1 cycle
//    -> grant order 0,1,...,15,0; each grant 3 cycles, 1 dead cycle between grants.
//  4 Timeout: MAX_HOLD=4, req=16'h8000 held
//    -> gnt high exactly 4 cycles, timeout=1 on the first 0 cycle, re-grant idx 0 one cycle later, repeating.
//  5 Timeout fairness: MAX_HOLD=4, rr_en=1, req=16'h8001 held
//    -> grants alternate idx 0, 15, 0, 15; timeout pulses each time.
//  6 Corner cases:
//    - rst asserted during GRANT -> gnt=0 next cycle, ptr back to 0.
//    - Owner drops req on the same edge the hold limit is hit -> timeout stays 0.

Source files
------------

// File: rtl/req_arbiter16.sv
// req_arbiter16: 16-way fixed/round-robin arbiter with registered held grant and hold-limit timeout
// Ports: clk, rst (sync, active-high); rr_en selects round-robin (1) or fixed priority (0);
// req request vector where index k maps to req[N-1-k]; gnt one-hot grant with the same mapping;
// gnt_idx encoded owner index; gnt_valid high while a grant is held; timeout pulses on forced release.
module req_arbiter16 #(
  parameter int N        = 16,
  parameter int IDX_W    = $clog2(N),
  parameter int MAX_HOLD = 64,
  parameter int HOLD_W   = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rr_en,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic [HOLD_W-1:0] HMAX = MAX_HOLD != 0 ? HOLD_W'(MAX_HOLD) : '1;
  state_t state_q, state_d;
  logic [N-1:0] gnt_q, gnt_d, reqr;
  logic [IDX_W-1:0] idx_q, idx_d, ptr_q, ptr_d, start, pick;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic to_q, to_d, own, limit;
  always_comb begin
    for (int i = 0; i < N; i++) reqr[i] = req[N-1-i];
    start = rr_en ? ptr_q : '0;
    pick = '0;
    // descending scan so the requester closest after start wins
    for (int i = N - 1; i >= 0; i--)
      if (reqr[IDX_W'((int'(start) + i) % N)]) pick = IDX_W'((int'(start) + i) % N);
    own = reqr[idx_q];
    limit = MAX_HOLD != 0 && hold_q == HMAX;
    state_d = state_q;
    idx_d = idx_q;
    hold_d = hold_q;
    ptr_d = ptr_q;
    to_d = 1'b0;
    if (state_q == IDLE) begin
      if (|req) begin
        state_d = GRANT;
        idx_d = pick;
        hold_d = HOLD_W'(1);
      end
    end else if (!own || limit) begin
      state_d = IDLE;
      to_d = own;
      ptr_d = rr_en ? IDX_W'((int'(idx_q) + 1) % N) : ptr_q;
    end else begin
      hold_d = hold_q == HMAX ? hold_q : hold_q + 1'b1;
    end
    for (int i = 0; i < N; i++) gnt_d[N-1-i] = state_d == GRANT && idx_d == IDX_W'(i);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q <= '0;
      idx_q <= '0;
      hold_q <= '0;
      ptr_q <= '0;
      to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      idx_q <= idx_d;
      hold_q <= hold_d;
      ptr_q <= ptr_d;
      to_q <= to_d;
    end
  end
  assign gnt = gnt_q;
  assign gnt_idx = idx_q;
  assign gnt_valid = |gnt_q;
  assign timeout = to_q;
endmodule

// File: tb/tb_req_arbiter16.sv
// tb_req_arbiter16: scoreboard bench for req_arbiter16 with MAX_HOLD=4
module tb_req_arbiter16;
  logic clk = 1'b0, rst = 1'b1, rr_en = 1'b0;
  logic [15:0] req = 16'hFFFF;
  logic [15:0] gnt;
  logic [3:0] gnt_idx;
  logic gnt_valid, timeout;
  req_arbiter16 #(.MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .rr_en(rr_en), .req(req),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
  );
  always #5 clk = ~clk;
  typedef struct {int idx; int len; int to; int gap;} exp_t;
  exp_t q[$];
  exp_t cur = '{-1, 0, 0, -1};
  int checks = 0, passed = 0, len = 0, gap = 0;
  bit mon_en = 1'b0, prev = 1'b0;
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_gnt;
    int c;
    c = 0;
    while (!gnt_valid && c < 20) begin
      tick;
      c++;
    end
    chk("grant_wait", 32'(c < 20), 1);
  endtask
  task automatic serve(input int n, input logic [15:0] m);
    wait_gnt;
    repeat (n - 1) tick;
    req = req & ~m;
    tick;
  endtask
  task automatic push(input int i, input int l, input int t, input int g);
    q.push_back('{i, l, t, g});
  endtask
  always @(negedge clk) begin
    bit fall;
    if (mon_en) begin
      fall = prev && !gnt_valid;
      chk("valid_eq_or", 32'(gnt_valid), 32'(|gnt));
      chk("onehot0", 32'($onehot0(gnt)), 1);
      chk("timeout", 32'(timeout), fall ? 32'(cur.to) : 0);
      if (gnt_valid && !prev) begin
        if (q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_grant: got idx %0d expected no grant", gnt_idx);
          cur = '{-1, 0, 0, -1};
        end else begin
          cur = q.pop_front();
          chk("gnt_idx", 32'(gnt_idx), 32'(cur.idx));
          chk("gnt", 32'(gnt), 32'(16'h8000) >> cur.idx);
          if (cur.gap >= 0) chk("dead_gap", 32'(gap), 32'(cur.gap));
        end
        len = 1;
      end else if (gnt_valid) len++;
      if (fall) chk("grant_len", 32'(len), 32'(cur.len));
      gap = gnt_valid ? 0 : (fall ? 1 : gap + 1);
      prev = gnt_valid;
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100us");
    $fatal(1);
  end
  initial begin
    tick;
    mon_en = 1'b1;
    tick;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_valid", 32'(gnt_valid), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_idx", 32'(gnt_idx), 0);
    push(0, 1, 0, -1);
    rst = 1'b0;
    serve(1, 16'hFFFF);
    rr_en = 1'b0;
    push(8, 3, 0, -1);
    push(15, 2, 0, 1);
    req = 16'h0081;
    serve(3, 16'h0080);
    serve(2, 16'h0001);
    rr_en = 1'b1;
    req = 16'hFFFF;
    for (int k = 0; k <= 16; k++) begin
      logic [15:0] m;
      m = 16'h8000 >> (k % 16);
      push(k % 16, 3, 0, k == 0 ? -1 : 1);
      serve(3, m);
      if (k < 16) req = req | m;
      else req = 16'h0000;
    end
    rr_en = 1'b0;
    push(7, 4, 0, -1);
    req = 16'h0100;
    serve(4, 16'h0100);
    req = 16'h8000;
    for (int i = 0; i < 3; i++) begin
      push(0, 4, 1, i == 0 ? -1 : 1);
      wait_gnt;
      repeat (4) tick;
    end
    req = 16'h0000;
    tick;
    rr_en = 1'b1;
    req = 16'hFFFF;
    push(1, 1, 0, -1);
    wait_gnt;
    rst = 1'b1;
    tick;
    chk("midrst_gnt", 32'(gnt), 0);
    chk("midrst_valid", 32'(gnt_valid), 0);
    chk("midrst_idx", 32'(gnt_idx), 0);
    chk("midrst_timeout", 32'(timeout), 0);
    req = 16'h8001;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(i % 2 ? 15 : 0, 4, 1, i == 0 ? -1 : 1);
      wait_gnt;
      repeat (4) tick;
    end
    req = 16'h0000;
    tick;
    tick;
    chk("queue_drained", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
